// File: rtl/pbkdf2_stage2.sv
// pbkdf2_stage2
// Final PBKDF2-HMAC-SHA256 stage of the scrypt(N,1,1) pipeline. It computes
// T1 = HMAC-SHA256(P, B || INT(1)) from the 1024-bit ROMix output B and the
// precomputed HMAC inner/outer midstates of the password P. One iterative
// SHA-256 compression engine is reused for four compressions: two over B,
// one padding block carrying INT(1), and the outer hash over the inner digest.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - synchronous reset, active HIGH (historical name kept)
//   init       - start request, level-sampled in IDLE/DONE
//   in         - salt block B, word 0 = in[1023:992]
//   ixor_hash  - SHA-256 state after (key ^ ipad), H0 = [255:224]
//   oxor_hash  - SHA-256 state after (key ^ opad), H0 = [255:224]
//   out        - final digest, H0 = [255:224]
//   valid      - out holds a completed result
module pbkdf2_stage2 (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic [1023:0] in,
    input  logic [255:0]  ixor_hash,
    input  logic [255:0]  oxor_hash,
    output logic [255:0]  out,
    output logic          valid
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t        state;
    logic [1023:0] salt;
    logic [255:0]  ohash;
    logic [255:0]  inner;
    logic [31:0]   hv [8];
    logic [31:0]   wv [8];
    logic [31:0]   w  [16];
    logic [5:0]    t;
    logic [1:0]    blk;

    logic [511:0]  msg;
    logic [31:0]   t1;
    logic [31:0]   t2;
    logic [31:0]   w_next;
    logic [31:0]   hsum [8];

    // Message for the current block. blk2 carries INT(1) plus padding for a
    // 1568-bit inner message; blk3 is the inner digest padded to 768 bits.
    always_comb begin
        msg = '0;
        case (blk)
            2'd0:    msg = salt[1023:512];
            2'd1:    msg = salt[511:0];
            2'd2:    msg = {32'h00000001, 32'h80000000, 416'd0, 32'h00000620};
            default: msg = {inner, 32'h80000000, 192'd0, 32'h00000300};
        endcase
    end

    // One SHA-256 round. w[0] always holds W[t]; w_next is W[t+16], which
    // keeps the 16-word window rolling without storing the full schedule.
    always_comb begin
        t1 = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[t] + w[0];
        t2 = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
        for (int i = 0; i < 8; i++) begin
            hsum[i] = hv[i] + wv[i];
        end
    end

    // Control FSM and datapath. After the blk2 add, the chaining value is
    // swapped for the outer midstate so blk3 computes the outer hash.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= IDLE;
            valid <= 1'b0;
            out   <= '0;
            blk   <= 2'd0;
            t     <= 6'd0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= 32'd0;
                wv[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (init) begin
                        salt  <= in;
                        ohash <= oxor_hash;
                        valid <= 1'b0;
                        blk   <= 2'd0;
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= ixor_hash[255 - 32*i -: 32];
                        end
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 8; i++) begin
                        wv[i] <= hv[i];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w[i] <= msg[511 - 32*i -: 32];
                    end
                    t     <= 6'd0;
                    state <= ROUND;
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i+1];
                    end
                    w[15] <= w_next;
                    t     <= t + 6'd1;
                    if (t == 6'd63) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (blk == 2'd3) begin
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= hsum[i];
                        end
                        out   <= {hsum[0], hsum[1], hsum[2], hsum[3],
                                  hsum[4], hsum[5], hsum[6], hsum[7]};
                        valid <= 1'b1;
                        state <= DONE;
                    end else if (blk == 2'd2) begin
                        inner <= {hsum[0], hsum[1], hsum[2], hsum[3],
                                  hsum[4], hsum[5], hsum[6], hsum[7]};
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= ohash[255 - 32*i -: 32];
                        end
                        blk   <= 2'd3;
                        state <= LOAD;
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= hsum[i];
                        end
                        blk   <= blk + 2'd1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbkdf2_stage2.sv
// tb_pbkdf2_stage2
// Self-checking bench for pbkdf2_stage2. A software SHA-256 / HMAC model
// predicts the digest when a run is accepted; a timing model predicts when
// valid must rise. A negedge compare process checks valid every cycle and
// out whenever its value is defined. Directed sequences cover reset, busy
// init, back-to-back runs, held init and reset racing init.
module tb_pbkdf2_stage2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init;
    logic [1023:0] in;
    logic [255:0]  ixor_hash;
    logic [255:0]  oxor_hash;
    logic [255:0]  out;
    logic          valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pbkdf2_stage2 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .in        (in),
        .ixor_hash (ixor_hash),
        .oxor_hash (oxor_hash),
        .out       (out),
        .valid     (valid)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule expanded up front.
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] block);
        logic [31:0] sched [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, ch, maj, tmp1, tmp2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) sched[i] = block[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3);
            s1 = rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10);
            sched[i] = sched[i-16] + s0 + sched[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            s1   = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            ch   = (v[4] & v[5]) ^ (~v[4] & v[6]);
            tmp1 = v[7] + s1 + ch + KT[i] + sched[i];
            s0   = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            maj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            tmp2 = s0 + maj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + tmp1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = tmp1 + tmp2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // HMAC-SHA256(P, B || INT(1)) from the two midstates.
    function automatic logic [255:0] pbkdf2_model(input logic [1023:0] b, input logic [255:0] ih, input logic [255:0] oh);
        logic [255:0] st;
        st = sha_compress(ih, b[1023:512]);
        st = sha_compress(st, b[511:0]);
        st = sha_compress(st, {32'h00000001, 32'h80000000, 416'd0, 32'h00000620});
        return sha_compress(oh, {st, 32'h80000000, 192'd0, 32'h00000300});
    endfunction

    task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Timing/result model, advanced on each rising edge.
    logic         m_seen  = 1'b0;
    logic         m_busy  = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_known = 1'b0;
    int           m_count = 0;
    logic [255:0] m_out   = '0;
    logic [255:0] m_next  = '0;

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            m_seen  = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_out   = '0;
            m_known = 1'b1;
        end else if (m_seen) begin
            if (!m_busy && init === 1'b1) begin
                m_busy  = 1'b1;
                m_count = 0;
                m_valid = 1'b0;
                m_known = 1'b0;
                m_next  = pbkdf2_model(in, ixor_hash, oxor_hash);
            end else if (m_busy) begin
                m_count++;
                if (m_count == 264) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    m_out   = m_next;
                    m_known = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_seen) begin
            check_output("valid_model", {255'd0, valid}, {255'd0, m_valid});
            if (m_known) check_output("out_model", out, m_out);
        end
    end

    task automatic apply_stimulus(input logic [31:0] seed);
        for (int i = 0; i < 32; i++) in[1023 - 32*i -: 32] = seed ^ (i * 32'h9e3779b9);
        for (int i = 0; i < 8; i++) begin
            ixor_hash[255 - 32*i -: 32] = (seed + 32'h1111) * (i + 3);
            oxor_hash[255 - 32*i -: 32] = (seed ^ 32'h5a5a5a5a) + i * 32'h01000193;
        end
    endtask

    // Called at a negedge with inputs set; raises init, holds it for
    // 'hold' samples, optionally re-pulses init with a new 'in' at cycle
    // poke_at, and checks that valid rises 264 edges after acceptance.
    task automatic wait_valid(input int hold, input int poke_at, input string name);
        int  n;
        init = 1'b1;
        @(posedge clk);
        n = 0;
        while (n <= 400) begin
            @(negedge clk);
            if (n == 0) check_output({name, "_valid_cleared"}, {255'd0, valid}, 256'd0);
            if (valid === 1'b1) break;
            if (n + 1 >= hold) init = 1'b0;
            if (poke_at > 0 && n == poke_at - 1) begin
                init = 1'b1;
                in   = ~in;
            end
            @(posedge clk);
            n++;
        end
        check_output({name, "_latency"}, 256'(n), 256'd264);
    endtask

    initial begin
        int found;
        reset_n   = 1'b1;
        init      = 1'b0;
        in        = '0;
        ixor_hash = '0;
        oxor_hash = '0;

        // Model pins: known single-block SHA-256 digests.
        check_output("pin_sha_abc",
            sha_compress(SHA_IV, {32'h61626380, 448'd0, 32'h00000018}),
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        check_output("pin_sha_empty",
            sha_compress(SHA_IV, {32'h80000000, 448'd0, 32'h00000000}),
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        repeat (3) @(negedge clk);
        check_output("reset_valid", {255'd0, valid}, 256'd0);
        check_output("reset_out", out, 256'd0);
        reset_n = 1'b0;
        @(negedge clk);

        // Reference-style vector, init held for two samples.
        apply_stimulus(32'hb2b80d34);
        in[31:0] = 32'h134ef52b;
        ixor_hash[255:224] = 32'ha7190a1a;
        ixor_hash[31:0]    = 32'hfa7c81ef;
        oxor_hash[255:224] = 32'h6bcf609b;
        oxor_hash[31:0]    = 32'h7736cee3;
        wait_valid(2, 0, "ref");

        // init re-pulsed while busy with a changed input.
        @(negedge clk);
        apply_stimulus(32'h0badf00d);
        wait_valid(1, 50, "busy");

        // Back-to-back: new vectors accepted straight from DONE.
        apply_stimulus(32'hc001d00d);
        wait_valid(1, 0, "b2b");

        // SHA core check with IV midstates and zero salt.
        in = '0;
        ixor_hash = SHA_IV;
        oxor_hash = SHA_IV;
        wait_valid(1, 0, "core");

        // Reset 100 cycles into a run.
        apply_stimulus(32'h12345678);
        init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        repeat (99) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("midrun_reset_valid", {255'd0, valid}, 256'd0);
        check_output("midrun_reset_out", out, 256'd0);
        reset_n = 1'b0;
        wait_valid(1, 0, "restart");

        // Reset and init at the same edge: reset wins, no run starts.
        reset_n = 1'b1;
        init    = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        init    = 1'b0;
        repeat (270) @(negedge clk);
        check_output("reset_wins_valid", {255'd0, valid}, 256'd0);

        // init held high: one run, then restart on the edge after DONE.
        apply_stimulus(32'hfeedbeef);
        wait_valid(1000000, 0, "hold");
        @(negedge clk);
        check_output("hold_restart_valid", {255'd0, valid}, 256'd0);
        init  = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                found = 1;
                break;
            end
        end
        check_output("hold_second_result", 256'(found), 256'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
